// File: rtl/long_divider_pkg.sv
// Shared widths and FSM state encoding for the shared long-divider front-end.
package long_divider_pkg;
    localparam int DIV_DW = 7;
    localparam int DIV_MW = 4;
    localparam int DIV_QW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } div_arb_state_t;
endpackage

// File: rtl/long_divider.sv
// Combinational restoring long divider: 7-bit dividend by 4-bit divisor.
// Quotient is truncated to DIV_QW bits; results are meaningless for M==0.
module long_divider
    import long_divider_pkg::*;
(
    input  logic [DIV_DW-1:0] D,
    input  logic [DIV_MW-1:0] M,
    output logic [DIV_QW-1:0] Q,
    output logic [DIV_MW-1:0] R
);
    logic [DIV_MW:0]   rem;
    logic [DIV_DW-1:0] dd;
    logic [DIV_QW-1:0] quo;
    logic              ge;

    always_comb begin
        rem = '0;
        dd  = D;
        quo = '0;
        ge  = 1'b0;
        // Dividend bits enter MSB-first; quotient shifts left so only the low bits survive.
        for (int i = 0; i < DIV_DW; i++) begin
            rem = {rem[DIV_MW-1:0], dd[DIV_DW-1]};
            dd  = dd << 1;
            ge  = (rem >= {1'b0, M});
            if (ge) rem = rem - {1'b0, M};
            quo = {quo[DIV_QW-2:0], ge};
        end
        Q = quo;
        R = rem[DIV_MW-1:0];
    end
endmodule

// File: rtl/long_divider_arbiter.sv
// Round-robin front-end sharing one long_divider between NUM_REQ requesters,
// with a fixed operand settle window and a valid/ready tagged response.
module long_divider_arbiter
    import long_divider_pkg::*;
#(
    parameter  int NUM_REQ       = 2,
    parameter  int SETTLE_CYCLES = 2,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DIV_DW*NUM_REQ-1:0] req_D,
    input  logic [DIV_MW*NUM_REQ-1:0] req_M,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [DIV_QW-1:0]         rsp_Q,
    output logic [DIV_MW-1:0]         rsp_R,
    output logic                      rsp_err,
    output logic                      busy
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    div_arb_state_t state_q;
    logic [IDW-1:0]    last_grant_q, id_q, rsp_id_q;
    logic [CW-1:0]     cnt_q;
    logic [DIV_DW-1:0] d_q;
    logic [DIV_MW-1:0] m_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [DIV_QW-1:0] rsp_q_q;
    logic [DIV_MW-1:0] rsp_r_q;

    logic [NUM_REQ-1:0][DIV_DW-1:0] req_d_arr;
    logic [NUM_REQ-1:0][DIV_MW-1:0] req_m_arr;
    assign req_d_arr = req_D;
    assign req_m_arr = req_M;

    logic [IDW-1:0] gnt;
    logic           gnt_vld;
    int             idx;

    // Walk from the farthest candidate inward so the nearest one after last_grant wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (req_valid[IDW'(idx)]) begin
                gnt     = IDW'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && gnt_vld) req_ready[gnt] = 1'b1;
    end

    logic [DIV_QW-1:0] div_q;
    logic [DIV_MW-1:0] div_r;
    logic              dbz, ovf, err_c;

    long_divider u_div (.D(d_q), .M(m_q), .Q(div_q), .R(div_r));

    assign dbz   = (m_q == '0);
    assign ovf   = ({1'b0, d_q} >= {m_q, {DIV_QW{1'b0}}});
    assign err_c = dbz | ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            id_q         <= '0;
            cnt_q        <= '0;
            d_q          <= '0;
            m_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_q_q      <= '0;
            rsp_r_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (gnt_vld) begin
                    d_q          <= req_d_arr[gnt];
                    m_q          <= req_m_arr[gnt];
                    id_q         <= gnt;
                    last_grant_q <= gnt;
                    cnt_q        <= CW'(SETTLE_CYCLES - 1);
                    state_q      <= ST_SETTLE;
                end
                ST_SETTLE: if (cnt_q == '0) begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_err_q   <= err_c;
                    rsp_q_q     <= err_c ? '0 : div_q;
                    rsp_r_q     <= err_c ? '0 : div_r;
                    state_q     <= ST_RESP;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_Q     = rsp_q_q;
    assign rsp_R     = rsp_r_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_long_divider_arbiter.sv
// Randomized and directed bench for long_divider_arbiter against a queue-based model.
module tb_long_divider_arbiter;
    localparam int NR = 4;
    localparam int SC = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [7*NR-1:0] req_D = '0;
    logic [4*NR-1:0] req_M = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [3:0]      rsp_Q, rsp_R;
    logic            rsp_err, busy;

    long_divider_arbiter #(.NUM_REQ(NR), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_D(req_D), .req_M(req_M), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_Q(rsp_Q), .rsp_R(rsp_R), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int d; int m; } op_t;
    typedef struct { int id; int q; int r; int err; } rsp_t;

    op_t  opq [NR][$];
    rsp_t rsp_log[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    bit   m_act = 0;
    int   m_E, m_D, m_M, m_id;
    int   m_last = NR - 1;
    int   hold_n = 0;
    bit   rnd_rdy = 0;
    int   grant_cyc = 0, first_vld_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (opq[i].size() > 0) return 1;
        return 0;
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= NR; k++)
            if (opq[(m_last + k) % NR].size() > 0) return (m_last + k) % NR;
        return -1;
    endfunction

    task automatic push(input int i, input int d, input int m);
        op_t o;
        o.d = d; o.m = m;
        opq[i].push_back(o);
    endtask

    // One clock cycle: drive, compare against the model, advance model and DUT.
    task automatic step();
        int g, age, e_q, e_r, e_err;
        bit exp_rv;
        rsp_t r;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (opq[i].size() > 0);
            if (opq[i].size() > 0) begin
                req_D[7*i +: 7] = 7'(opq[i][0].d);
                req_M[4*i +: 4] = 4'(opq[i][0].m);
            end
        end
        exp_rv = m_act && (cyc >= m_E + SC);
        age = exp_rv ? cyc - (m_E + SC) : 0;
        rsp_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : (age >= hold_n);
        #1;
        g = m_act ? -1 : rr_pick();
        chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
        chk("busy", int'(busy), int'(m_act));
        chk("rsp_valid", int'(rsp_valid), int'(exp_rv));
        if (exp_rv) begin
            e_err = (m_M == 0) ? 1 : ((m_D / m_M) > 15);
            e_q = e_err ? 0 : m_D / m_M;
            e_r = e_err ? 0 : m_D % m_M;
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_Q", int'(rsp_Q), e_q);
            chk("rsp_R", int'(rsp_R), e_r);
            chk("rsp_err", int'(rsp_err), e_err);
        end
        if (rsp_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (exp_rv && rsp_ready) begin
            r.id = int'(rsp_id); r.q = int'(rsp_Q); r.r = int'(rsp_R); r.err = int'(rsp_err);
            rsp_log.push_back(r);
            m_act = 0;
        end
        if (g >= 0) begin
            m_act = 1; m_E = cyc + 1; m_last = g; m_id = g;
            m_D = opq[g][0].d; m_M = opq[g][0].m;
            grant_cyc = cyc + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (g >= 0) void'(opq[g].pop_front());
        @(negedge clk);
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((m_act || pending()) && n < budget) begin
            step();
            n++;
        end
        n_cmp++;
        if (m_act || pending()) begin
            n_bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_Q", int'(rsp_Q), 0);
        chk("rst_rsp_R", int'(rsp_R), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        m_act = 0;
        m_last = NR - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_log(input int k, input int id, input int q, input int r, input int err);
        if (k >= rsp_log.size()) begin
            n_cmp++; n_bad++;
            $display("FAIL log_missing: got %0d responses, expected entry %0d", rsp_log.size(), k);
        end else begin
            chk("log_id", rsp_log[k].id, id);
            chk("log_Q", rsp_log[k].q, q);
            chk("log_R", rsp_log[k].r, r);
            chk("log_err", rsp_log[k].err, err);
        end
    endtask

    initial begin
        #2;
        do_reset();

        // Single request, latency pin
        rsp_log.delete();
        first_vld_cyc = -1;
        push(0, 7, 2);
        run_idle(50);
        chk_log(0, 0, 3, 1, 0);
        chk("latency", first_vld_cyc - grant_cyc, 2);

        // Two simultaneous requesters from reset
        do_reset();
        rsp_log.delete();
        push(0, 9, 4);
        push(1, 12, 5);
        run_idle(50);
        chk_log(0, 0, 2, 1, 0);
        chk_log(1, 1, 2, 2, 0);

        // Error boundaries
        rsp_log.delete();
        push(2, 6, 0);
        push(2, 127, 1);
        push(2, 15, 1);
        run_idle(60);
        chk_log(0, 2, 0, 0, 1);
        chk_log(1, 2, 0, 0, 1);
        chk_log(2, 2, 15, 0, 0);

        // Backpressure held for 5 cycles with a competing requester
        do_reset();
        rsp_log.delete();
        hold_n = 5;
        push(0, 6, 2);
        push(1, 5, 1);
        run_idle(60);
        hold_n = 0;
        chk_log(0, 0, 3, 0, 0);
        chk_log(1, 1, 5, 0, 0);

        // Reset during SETTLE aborts; re-request completes
        rsp_log.delete();
        push(0, 7, 2);
        step();
        step();
        do_reset();
        push(0, 7, 2);
        run_idle(50);
        chk("abort_count", rsp_log.size(), 1);
        chk_log(0, 0, 3, 1, 0);

        // Fairness with all requesters continuously valid
        do_reset();
        rsp_log.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++)
                push(i, int'($urandom_range(0, 127)), int'($urandom_range(1, 15)));
        run_idle(200);
        chk("fair_count", rsp_log.size(), 8);
        for (int k = 0; k < rsp_log.size() && k < 8; k++)
            chk("fair_id", rsp_log[k].id, k % NR);

        // Random traffic with random response backpressure
        rnd_rdy = 1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0)
                push(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 15)));
            step();
        end
        run_idle(3000);
        rnd_rdy = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/long_divider_arbiter.md
# long_divider_arbiter

Sequential front-end that shares one combinational `long_divider` (7-bit dividend, 4-bit divisor, 4-bit quotient and remainder) between `NUM_REQ` requesters. It grants requesters round-robin and registers the operands, holding them stable for a fixed settle window. It then captures the quotient and remainder, flags divide-by-zero and quotient overflow, and returns the result over a valid/ready response channel tagged with the requester ID. It sits between the divider datapath and its client blocks.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `SETTLE_CYCLES`, 2: cycles operands are held on the divider before capture, ≥1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_D`  in  7*NUM_REQ  dividends; requester i in bits [7i+6:7i].
- `req_M`  in  4*NUM_REQ  divisors; requester i in bits [4i+3:4i].
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  max(1,$clog2(NUM_REQ))  granted requester index.
- `rsp_Q`  out  4  quotient.
- `rsp_R`  out  4  remainder.
- `rsp_err`  out  1  divide-by-zero or overflow.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, SETTLE, RESP.
- IDLE:
  - Grant goes to the first requester with `req_valid` high, searching from `last_grant+1` modulo NUM_REQ.
  - `req_ready[g]` is high combinationally in IDLE only, and only for the granted index.
  - On the accept edge, the block latches `req_D[g]`, `req_M[g]` and `g`, sets `last_grant=g`, loads the counter with `SETTLE_CYCLES-1` and moves to SETTLE.
- SETTLE:
  - Latched operands drive the divider.
  - The counter decrements each cycle.
  - At counter 0, the block registers the response fields and moves to RESP.
- Error detection, computed from the latched operands:
  - `dbz = (M==0)`.
  - `ovf = (D >= {M,4'b0000})`, i.e. the quotient exceeds 15.
  - On `rsp_err=1`, `rsp_Q=0` and `rsp_R=0`; the divider outputs are ignored.
  - Otherwise `rsp_Q` and `rsp_R` are the divider outputs, with `D = Q*M + R` and `R < M`.
- RESP:
  - `rsp_valid=1`; all `rsp_*` fields stay stable until `rsp_ready` is sampled high.
  - On that edge the FSM returns to IDLE. There is no new grant in the same cycle.
- Requests are never dropped. A requester holds `req_valid` and its operands until it sees `req_ready`.
- Requesters that are not granted see `req_ready=0`.

## Timing
- Reset values (asynchronous):
  - `state=IDLE`, `last_grant=NUM_REQ-1`, so requester 0 wins first.
  - Counter 0; `rsp_valid`, `rsp_id`, `rsp_Q`, `rsp_R`, `rsp_err` all 0; `busy=0`.
- Latency: accept edge E0 → `rsp_valid` high after edge E0+SETTLE_CYCLES.
- Back-to-back: the next accept can occur at the earliest one cycle after the response handshake edge. Minimum period is SETTLE_CYCLES+2 cycles.
- `req_ready` is all zeros whenever `busy=1`.
- Reset mid-operation aborts the operation. The in-flight result is lost, and the requester must re-request.
- If `rsp_ready` is high on the first RESP cycle, the response completes in one cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.

## Structure
- `long_divider_pkg` holds:
  - Width constants: `DIV_DW=7`, `DIV_MW=4`, `DIV_QW=4`.
  - The FSM state enum `div_arb_state_t`.
- Sub-module: one instance of the existing `long_divider` (ports `D`, `M`, `Q`, `R`).
- Round-robin pick, error detection, counter and FSM stay in this module.

## Test plan
- Single request, requester 0, D=7, M=2, SETTLE_CYCLES=2 → `rsp_valid` two cycles after accept; Q=3, R=1, err=0, id=0.
- Requesters 0 and 1 both valid from reset, operands 9/4 and 12/5 → grants 0 then 1; responses Q=2,R=1 then Q=2,R=2.
- D=6, M=0 → err=1, Q=0, R=0. D=127, M=1 → err=1, Q=0, R=0. D=15, M=1 → err=0, Q=15, R=0.
- `rsp_ready` low for 5 cycles with a 6/2 result → `rsp_valid`, Q=3, R=0, id held stable; `req_ready` stays 0 throughout; no second grant.
- `rst` asserted during SETTLE → all outputs 0 immediately; after release, requester 0 re-requests 7/2 and receives Q=3, R=1.
- All NUM_REQ=4 requesters continuously valid for 8 operations → `rsp_id` sequence 0,1,2,3,0,1,2,3.
